// File: rtl/instruction_memory_ctrl.sv
// instruction_memory_ctrl: two-phase instruction memory.
// BOOT: loader writes words and they are counted; RUN: registered, stallable fetch port.
// Optional macro INSTR_MEM_PARITY_EN adds per-word even parity and the parity_error port.
module instruction_memory_ctrl #(
    parameter int unsigned                  DATA_WIDTH = 32,
    parameter int unsigned                  ADDR_WIDTH = 10,
    parameter int unsigned                  DEPTH      = 1024,
    parameter logic        [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  fetch_valid,
    output logic                  addr_error,
    output logic                  running,
`ifdef INSTR_MEM_PARITY_EN
    output logic                  parity_error,
`endif
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CNT_W   = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   err_q,   err_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   load_acc_c;
    logic                   load_in_range_c;
    logic                   fetch_acc_c;
    logic                   fetch_in_range_c;
    logic [IDX_W-1:0]       load_idx_c;
    logic [IDX_W-1:0]       fetch_idx_c;
    logic [DATA_WIDTH-1:0]  rd_word_c;

`ifdef INSTR_MEM_PARITY_EN
    logic                   par_mem_q [DEPTH];
    logic                   par_err_q, par_err_d;
    logic                   rd_par_c;
`endif

    assign load_in_range_c  = {1'b0, load_address}  < DEPTH_C;
    assign fetch_in_range_c = {1'b0, fetch_address} < DEPTH_C;
    assign load_acc_c       = (state_q == BOOT) && load_en;
    assign fetch_acc_c      = fetch_req && !stall;
    assign load_idx_c       = IDX_W'(load_address);
    assign fetch_idx_c      = IDX_W'(fetch_address);
    assign rd_word_c        = mem_q[fetch_idx_c];

    // Memory array: written only by accepted in-range BOOT loads; never cleared by reset.
    always_ff @(posedge clock) begin
        if (reset && load_acc_c && load_in_range_c) begin
            mem_q[load_idx_c] <= load_data;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    assign rd_par_c = par_mem_q[fetch_idx_c];

    // Even-parity side array, written alongside the data word.
    always_ff @(posedge clock) begin
        if (reset && load_acc_c && load_in_range_c) begin
            par_mem_q[load_idx_c] <= ^load_data;
        end
    end
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= BOOT;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef INSTR_MEM_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
`ifdef INSTR_MEM_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next-state: phase transition, load accounting, fetch response.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        count_d = count_q;
`ifdef INSTR_MEM_PARITY_EN
        par_err_d = par_err_q;
`endif

        if ((state_q == BOOT) && load_done) begin
            state_d = RUN;
        end

        if (load_acc_c) begin
            if (load_in_range_c) begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (fetch_acc_c) begin
            valid_d = 1'b1;
            instr_d = NOP_WORD;
`ifdef INSTR_MEM_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (!fetch_in_range_c) begin
                err_d = 1'b1;
            end else if (state_q == RUN) begin
`ifdef INSTR_MEM_PARITY_EN
                if ((^rd_word_c) != rd_par_c) begin
                    par_err_d = 1'b1;
                end else begin
                    instr_d = rd_word_c;
                end
`else
                instr_d = rd_word_c;
`endif
            end
        end else if (!stall) begin
            valid_d = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            par_err_d = 1'b0;
`endif
        end
    end

    assign instruction = instr_q;
    assign fetch_valid = valid_q;
    assign addr_error  = err_q;
    assign load_count  = count_q;
    assign running     = (state_q == RUN);
`ifdef INSTR_MEM_PARITY_EN
    assign parity_error = par_err_q;
`endif

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Bench for instruction_memory_ctrl: directed plan steps followed by random traffic,
// all checked every cycle against a behavioural model of the memory and its lifecycle.
module tb_instruction_memory_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clock;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_address;
    logic [DW-1:0] load_data;
    logic          load_done;
    logic          fetch_req;
    logic [AW-1:0] fetch_address;
    logic          stall;
    logic [DW-1:0] instruction;
    logic          fetch_valid;
    logic          addr_error;
    logic          running;
    logic [AW:0]   load_count;
`ifdef INSTR_MEM_PARITY_EN
    logic          parity_error;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] m_mem [16];
    bit            m_wr  [16];
    bit            m_run, m_valid, m_err, m_iknown;
    logic [DW-1:0] m_instr;
    int            m_cnt;

    instruction_memory_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .load_en       (load_en),
        .load_address  (load_address),
        .load_data     (load_data),
        .load_done     (load_done),
        .fetch_req     (fetch_req),
        .fetch_address (fetch_address),
        .stall         (stall),
        .instruction   (instruction),
        .fetch_valid   (fetch_valid),
        .addr_error    (addr_error),
        .running       (running),
`ifdef INSTR_MEM_PARITY_EN
        .parity_error  (parity_error),
`endif
        .load_count    (load_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural update for one rising edge, from the inputs presented this cycle.
    task automatic model_step();
        if (!reset) begin
            m_run = 0; m_valid = 0; m_err = 0; m_cnt = 0;
            m_instr = NOP; m_iknown = 1;
            return;
        end
        if (fetch_req && !stall) begin
            m_valid = 1;
            if (int'(fetch_address) >= int'(DEPTH)) begin
                m_instr = NOP; m_iknown = 1; m_err = 1;
            end else if (!m_run) begin
                m_instr = NOP; m_iknown = 1;
            end else begin
                m_instr  = m_mem[fetch_address];
                m_iknown = m_wr[fetch_address];
            end
        end else if (!stall) begin
            m_valid = 0;
        end
        if (!m_run && load_en) begin
            if (int'(load_address) < int'(DEPTH)) begin
                m_mem[load_address] = load_data;
                m_wr[load_address]  = 1;
                if (m_cnt < (1 << AW)) m_cnt++;
            end else begin
                m_err = 1;
            end
        end
        if (load_done) m_run = 1;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        chk("addr_error",  32'(addr_error),  32'(m_err));
        chk("running",     32'(running),     32'(m_run));
        chk("load_count",  32'(load_count),  32'(m_cnt));
        if (m_iknown) chk("instruction", instruction, m_instr);
`ifdef INSTR_MEM_PARITY_EN
        chk("parity_error", 32'(parity_error), 32'(0));
`endif
    endtask

    task automatic apply(input logic r, input logic le, input logic [AW-1:0] la,
                         input logic [DW-1:0] ld, input logic dn, input logic fr,
                         input logic [AW-1:0] fa, input logic st);
        reset = r; load_en = le; load_address = la; load_data = ld;
        load_done = dn; fetch_req = fr; fetch_address = fa; stall = st;
        cycle();
    endtask

    task automatic do_reset();             apply(1'b0, 0, '0, '0, 0, 0, '0, 0); endtask
    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
                                           apply(1'b1, 1, a, d, 0, 0, '0, 0); endtask
    task automatic do_done();              apply(1'b1, 0, '0, '0, 1, 0, '0, 0); endtask
    task automatic do_fetch(input logic [AW-1:0] a);
                                           apply(1'b1, 0, '0, '0, 0, 1, a, 0); endtask
    task automatic do_idle();              apply(1'b1, 0, '0, '0, 0, 0, '0, 0); endtask

    initial begin
        for (int i = 0; i < 16; i++) begin m_wr[i] = 0; m_mem[i] = '0; end
        m_run = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_instr = NOP; m_iknown = 0;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", 32'(fetch_valid), 32'(0));

        // Program load then enter RUN
        do_load(4'd0, 32'h00A22000);
        do_load(4'd1, 32'h08A21800);
        do_load(4'd2, 32'h0C820004);
        chk("plan1_cnt_boot", 32'(load_count), 32'd3);
        chk("plan1_run_boot", 32'(running), 32'd0);
        do_done();
        chk("plan1_running", 32'(running), 32'd1);
        chk("plan1_cnt", 32'(load_count), 32'd3);

        // Back-to-back fetches
        do_fetch(4'd0);
        chk("plan2_w0", instruction, 32'h00A22000);
        do_fetch(4'd1);
        chk("plan2_w1", instruction, 32'h08A21800);
        do_fetch(4'd2);
        chk("plan2_w2", instruction, 32'h0C820004);
        chk("plan2_v2", 32'(fetch_valid), 32'd1);
        do_idle();
        chk("plan2_idle_v", 32'(fetch_valid), 32'd0);
        chk("plan2_idle_hold", instruction, 32'h0C820004);

        // Stall holds output and blocks the pending request
        do_fetch(4'd1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 0, '0, '0, 0, 1, 4'd2, 1);
            chk("plan3_hold_i", instruction, 32'h08A21800);
            chk("plan3_hold_v", 32'(fetch_valid), 32'd1);
        end
        apply(1'b1, 0, '0, '0, 0, 1, 4'd2, 0);
        chk("plan3_after", instruction, 32'h0C820004);

        // Second session: BOOT fetch, collision, out-of-range accesses, RUN load ignored
        do_reset();
        do_load(4'd0, 32'hDEADBEEF);
        do_fetch(4'd0);
        chk("plan5_boot_fetch", instruction, NOP);
        apply(1'b1, 1, 4'd3, 32'hCAFEF00D, 0, 1, 4'd3, 0);
        chk("collide_nop", instruction, NOP);
        do_load(4'd5, 32'h11111111);
        chk("plan4_err", 32'(addr_error), 32'd1);
        chk("plan4_cnt", 32'(load_count), 32'd2);
        do_done();
        do_load(4'd0, 32'h12345678);
        do_fetch(4'd0);
        chk("plan5_run_fetch", instruction, 32'hDEADBEEF);
        do_fetch(4'd7);
        chk("plan4_oor_i", instruction, NOP);
        chk("plan4_oor_v", 32'(fetch_valid), 32'd1);
        do_fetch(4'd1);
        chk("plan4_sticky", 32'(addr_error), 32'd1);

        // Reset in the middle of a fetch stream
        do_fetch(4'd2);
        apply(1'b0, 1, 4'd1, 32'hBADBAD00, 1, 1, 4'd2, 0);
        chk("plan6_valid", 32'(fetch_valid), 32'd0);
        chk("plan6_run", 32'(running), 32'd0);
        chk("plan6_cnt", 32'(load_count), 32'd0);
        chk("plan6_err", 32'(addr_error), 32'd0);
        do_done();
        do_fetch(4'd2);
        chk("plan6_refetch", instruction, 32'h0C820004);
        do_fetch(4'd1);
        chk("plan6_reset_nowrite", instruction, 32'h08A21800);

        // Count saturation; last load coincides with load_done
        do_reset();
        for (int i = 0; i < 17; i++) do_load(4'(i % 4), 32'(i));
        chk("sat_cnt", 32'(load_count), 32'd16);
        apply(1'b1, 1, 4'd3, 32'h3333_0003, 1, 0, '0, 0);
        chk("sat_cnt_hold", 32'(load_count), 32'd16);
        do_fetch(4'd3);
        chk("load_with_done", instruction, 32'h3333_0003);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            apply(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_memory_ctrl.md
Name: instruction_memory_ctrl

Overview:
Parametrised instruction memory with a two-phase lifecycle.
- BOOT phase: an external loader writes the program word by word. The block counts words written.
- RUN phase: the fetch stage reads instructions through a registered, stallable request/valid port.
Sits between the program loader and the fetch stage of the processor. Replaces the fixed-content, combinational-read instruction RAM.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 10, address width for both the load and fetch ports
DEPTH, 1024, number of implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH
NOP_WORD, 0, word returned for blocked or out-of-range fetches

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
load_en  in  1  write strobe for the loader; honoured in BOOT only
load_address  in  ADDR_WIDTH  write address
load_data  in  DATA_WIDTH  write data
load_done  in  1  one-cycle pulse; moves the block from BOOT to RUN
fetch_req  in  1  fetch request from the fetch stage
fetch_address  in  ADDR_WIDTH  fetch address
stall  in  1  holds the output register and rejects new requests
instruction  out  DATA_WIDTH  registered instruction word
fetch_valid  out  1  instruction holds the result of an accepted request
addr_error  out  1  sticky; set by any out-of-range load or fetch
running  out  1  1 in RUN, 0 in BOOT
load_count  out  ADDR_WIDTH+1  number of accepted in-range writes since reset

Behaviour:
Reset (reset=0 at a clock edge):
- state=BOOT; running=0; fetch_valid=0; instruction=NOP_WORD; addr_error=0; load_count=0.
- Memory array contents are not cleared.

State machine:
- BOOT -> RUN on load_done=1.
- RUN -> BOOT only via reset.
- load_done in RUN is ignored.

Loads:
- Accepted when state=BOOT and load_en=1.
- load_address < DEPTH: mem[load_address] <= load_data at the edge; load_count increments, saturating at 2**ADDR_WIDTH.
- load_address >= DEPTH: no write, no count; addr_error <= 1.
- load_en and load_done in the same cycle: the write is performed, then the state moves to RUN.
- load_en in RUN: ignored; no write and no error.

Fetch (one-cycle latency):
- A request is accepted when fetch_req=1 and stall=0.
- At the next edge: fetch_valid <= 1 and instruction <= mem[fetch_address].
- Request in BOOT: accepted, but returns NOP_WORD with fetch_valid=1.
- fetch_address >= DEPTH: returns NOP_WORD with fetch_valid=1; addr_error <= 1.
- fetch_req=0 and stall=0: fetch_valid <= 0; instruction holds its last value.
- stall=1: instruction and fetch_valid hold; the request is not accepted and must be re-presented by the fetch stage.
- Back-to-back requests: one word per cycle, no bubbles.

Load/fetch collision:
- Same address in the same BOOT cycle: the fetch returns NOP_WORD, because BOOT fetches always return NOP_WORD.

Reset mid-operation:
- Reset wins over every other input in that cycle.
- Any in-flight fetch is discarded; fetch_valid=0 next cycle.

Optional Feature:
INSTR_MEM_PARITY_EN
- Defined:
  - Each word is stored with an even-parity bit computed on write.
  - On a fetch, the parity is recomputed.
  - On mismatch: output parity_error=1 for that fetch_valid cycle, and instruction=NOP_WORD.
  - The output port parity_error exists only when the macro is defined.
- Undefined: no parity storage, no parity_error port, and no change to any other timing or behaviour.

Test Plan:
1. Reset, then in BOOT load addr 0=0x00A22000, addr 1=0x08A21800, addr 2=0x0C820004, then pulse load_done -> load_count=3, running=1 the cycle after load_done.
2. In RUN, fetch addrs 0,1,2 back-to-back -> fetch_valid=1 on cycles 1-3 after the first request; instruction=0x00A22000, 0x08A21800, 0x0C820004 in order.
3. Fetch addr 1 with stall=1 asserted for 3 cycles after acceptance -> instruction stays 0x08A21800, fetch_valid stays 1; the next request is accepted only after stall drops.
4. With DEPTH=4, load addr 5 in BOOT, then fetch addr 7 in RUN -> no write, load_count unchanged, fetch returns 0x00000000 with fetch_valid=1, addr_error=1 and sticky.
5. In BOOT, fetch addr 0 after writing 0xDEADBEEF there -> instruction=0x00000000. Then in RUN, load_en with 0x12345678 to addr 0 and fetch addr 0 -> returns 0xDEADBEEF.
6. Assert reset during a fetch stream -> the next cycle shows fetch_valid=0, running=0, load_count=0, addr_error=0. A re-fetch after load_done returns the previously loaded contents.
